// File: rtl/mdu_sequencer.sv
// Multi-cycle MULTU/DIVU unit: 32-step shift-add multiply and restoring divide into HI/LO, with stall and MTHI/MTLO.
// Optional macro MDU_SIGNED_EN adds signed MULT/DIV (AluOP 13/14) via magnitude core plus one fix-up cycle.
module mdu_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic [4:0]       LOGISIM_CLOCK_TREE_0,
    input  logic             Reset_n,
    input  logic [3:0]       AluOP,
    input  logic             Start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             HiWe,
    input  logic             LoWe,
    input  logic [WIDTH-1:0] WData,
    output logic             Busy,
    output logic             Done,
    output logic             Stall,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam logic [3:0] OP_MULTU = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    logic clk, tick, unused_clk_bits;
    assign clk             = LOGISIM_CLOCK_TREE_0[4];
    assign tick            = LOGISIM_CLOCK_TREE_0[2];
    assign unused_clk_bits = ^{LOGISIM_CLOCK_TREE_0[3], LOGISIM_CLOCK_TREE_0[1:0]};

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opa;
    logic             mul_op, div_op, go, last, div0;
    logic [WIDTH-1:0] x_mag, y_mag, div0_hi;
    state_t           fin_state;

`ifdef MDU_SIGNED_EN
    localparam logic [3:0] OP_MULT = 4'd13;
    localparam logic [3:0] OP_DIV  = 4'd14;
    logic sgn_op, op_sgn, op_mul, neg_p, neg_r;
    logic [2*WIDTH-1:0] prod_neg;
    assign sgn_op    = (AluOP == OP_MULT) | (AluOP == OP_DIV);
    assign mul_op    = (AluOP == OP_MULTU) | (AluOP == OP_MULT);
    assign div_op    = (AluOP == OP_DIVU) | (AluOP == OP_DIV);
    assign x_mag     = (sgn_op & X[WIDTH-1]) ? -X : X;
    assign y_mag     = (sgn_op & Y[WIDTH-1]) ? -Y : Y;
    assign div0_hi   = neg_r ? -acc_lo : acc_lo;
    assign fin_state = op_sgn ? S_FIX : S_DONE;
    assign prod_neg  = -{HI, LO};
`else
    assign mul_op    = (AluOP == OP_MULTU);
    assign div_op    = (AluOP == OP_DIVU);
    assign x_mag     = X;
    assign y_mag     = Y;
    assign div0_hi   = acc_lo;
    assign fin_state = S_DONE;
`endif

    assign go   = Start & (mul_op | div_op);
    assign last = (cnt == CNT_W'(WIDTH - 1));
    assign div0 = (opa == '0);

    // Multiply step: {acc_hi, acc_lo} holds {partial, remaining multiplier}
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opa} : '0);
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // Divide step: {acc_hi, acc_lo} holds {remainder, dividend/quotient}
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic             fits;
    logic [WIDTH-1:0] div_hi_n, div_lo_n;
    assign rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign trial    = {1'b0, rem_sh} - {2'b00, opa};
    assign fits     = ~trial[WIDTH+1];
    assign div_hi_n = fits ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_lo_n = {acc_lo[WIDTH-2:0], fits};

    always_ff @(posedge clk) begin
        if (tick) begin
            if (!Reset_n) state <= S_IDLE;
            else          state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (go) state_n = mul_op ? S_MUL : S_DIV;
            S_MUL:   if (last) state_n = fin_state;
            S_DIV:   if (div0) state_n = S_DONE;
                     else if (last) state_n = fin_state;
            S_FIX:   state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        Busy  = 1'b0;
        Done  = 1'b0;
`ifdef MDU_SIGNED_EN
        Busy  = (state == S_MUL) | (state == S_DIV) | (state == S_FIX);
`else
        Busy  = (state == S_MUL) | (state == S_DIV);
`endif
        Done  = (state == S_DONE);
        Stall = Busy | ((state == S_IDLE) & go);
    end

    always_ff @(posedge clk) begin
        if (tick) begin
            if (!Reset_n) begin
                HI     <= '0;
                LO     <= '0;
                cnt    <= '0;
                acc_hi <= '0;
                acc_lo <= '0;
                opa    <= '0;
`ifdef MDU_SIGNED_EN
                op_sgn <= 1'b0;
                op_mul <= 1'b0;
                neg_p  <= 1'b0;
                neg_r  <= 1'b0;
`endif
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (HiWe) HI <= WData;
                        if (LoWe) LO <= WData;
                        if (state == S_IDLE && go) begin
                            acc_hi <= '0;
                            cnt    <= '0;
                            acc_lo <= mul_op ? y_mag : x_mag;
                            opa    <= mul_op ? x_mag : y_mag;
`ifdef MDU_SIGNED_EN
                            op_sgn <= sgn_op;
                            op_mul <= mul_op;
                            neg_p  <= sgn_op & (X[WIDTH-1] ^ Y[WIDTH-1]);
                            neg_r  <= sgn_op & X[WIDTH-1];
`endif
                        end
                    end
                    S_MUL: begin
                        acc_hi <= mul_hi_n;
                        acc_lo <= mul_lo_n;
                        cnt    <= last ? '0 : cnt + CNT_W'(1);
                        if (last) begin
                            HI <= mul_hi_n;
                            LO <= mul_lo_n;
                        end
                    end
                    S_DIV: begin
                        if (div0) begin
                            HI <= div0_hi;
                            LO <= '1;
                        end else begin
                            acc_hi <= div_hi_n;
                            acc_lo <= div_lo_n;
                            cnt    <= last ? '0 : cnt + CNT_W'(1);
                            if (last) begin
                                HI <= div_hi_n;
                                LO <= div_lo_n;
                            end
                        end
                    end
`ifdef MDU_SIGNED_EN
                    S_FIX: begin
                        if (op_mul) begin
                            if (neg_p) {HI, LO} <= prod_neg;
                        end else begin
                            if (neg_p) LO <= -LO;
                            if (neg_r) HI <= -HI;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide unit and controller for the ALU ops OP_MULTU (3) and OP_DIVU (4). The combinational ALU returns 0 for these ops.
- Accepts an issue request from EX, runs a 32-iteration shift-add multiply or restoring divide, and writes the architectural HI/LO registers.
- Drives a pipeline stall while running. Also services MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand width. HI/LO each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- LOGISIM_CLOCK_TREE_0  input  5  clock bundle; state updates on rising edge of bit [4] when bit [2] (tick enable) is high.
- Reset_n  input  1  synchronous, active-low reset.
- AluOP  input  4  EX-stage ALU opcode.
- Start  input  1  EX holds a valid op for this unit.
- X  input  WIDTH  rs operand (multiplicand / dividend).
- Y  input  WIDTH  rt operand (multiplier / divisor).
- HiWe  input  1  MTHI write strobe.
- LoWe  input  1  MTLO write strobe.
- WData  input  WIDTH  MTHI/MTLO data.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse; HI/LO hold the new result.
- Stall  output  1  freeze IF/ID/EX (combinational).
- HI  output  WIDTH  HI register.
- LO  output  WIDTH  LO register.

Behaviour:
- Clock and reset:
  - "Edge" means an enabled clock edge.
  - Reset_n=0 at an edge forces: state IDLE, HI=0, LO=0, counter=0, internal accumulators=0, Busy=0, Done=0.
  - Reset mid-operation aborts the operation with no HI/LO write.
- States: IDLE, MUL, DIV, DONE.
- Qualified start: go = Start & (AluOP==3 | AluOP==4), plus 13/14 under the optional feature. It is accepted only in IDLE.
- IDLE:
  - go with AluOP=3 → MUL. Latch X, Y, clear the 64-bit accumulator, counter=0.
  - go with AluOP=4 → DIV. Latch X, Y, remainder=0, counter=0.
  - Start with any other AluOP is ignored.
- MUL, one iteration per edge (LSB-first shift-add):
  - If multiplier[0], add the multiplicand into the upper half.
  - Shift the 33-bit carry/accumulator right by 1.
- DIV, one iteration per edge (restoring):
  - Shift {rem,quot} left by 1 and trial-subtract the divisor.
  - If the result is non-negative, keep it and set quot[0]=1.
- Completion:
  - At the edge where counter==WIDTH-1, counter wraps to 0, state → DONE, and HI/LO are loaded in the same edge.
  - MULTU: HI=product[63:32], LO=product[31:0].
  - DIVU: LO=quotient, HI=remainder.
- Divide by zero: Y==0 skips iteration. The next edge goes directly to DONE with HI=X, LO=32'hFFFFFFFF (1-cycle busy).
- DONE: Done=1 for exactly one cycle, then → IDLE unconditionally. Start seen in DONE is ignored, because it belongs to the completed instruction.
- Busy = (state==MUL | state==DIV).
- Stall = Busy | (state==IDLE & go).
- Latency:
  - Accept edge E0.
  - Result written at edge E32.
  - Done high in the cycle after E32.
  - Stall high for 33 cycles: the accept cycle plus 32 iteration cycles.
  - Next operation can be accepted in the cycle after DONE, i.e. the back-to-back issue gap is 1 cycle.
- MTHI/MTLO:
  - HiWe/LoWe load WData into HI/LO in IDLE or DONE. Both strobes may fire together.
  - Ignored in MUL/DIV; the pipeline is stalled then, so this does not occur architecturally.
  - Write plus go in the same IDLE cycle: the write applies, the op starts, and the completion overwrites HI/LO.
- HI/LO are never disturbed except by completion, MTHI/MTLO, or reset.

Optional Feature:
- Macro: MDU_SIGNED_EN.
- Defined:
  - AluOP=13 (MULT) and 14 (DIV) are also accepted.
  - Operands are converted to magnitude, the unsigned core runs, then the result is fixed up:
    - MULT: product negated if X[31]^Y[31].
    - DIV: quotient negated if X[31]^Y[31]; remainder takes the sign of X.
  - Adds one fix-up cycle before DONE, giving 34 Stall cycles.
  - Divide by zero behaves the same as DIVU.
- Undefined: AluOP 13/14 are ignored like any non-MDU op; no extra cycle or logic.

Test Plan:
- Reset_n=0 two edges, then release → HI=0, LO=0, Busy=0, Done=0, Stall=0.
- MULTU X=7, Y=6 → Stall high 33 cycles; Done pulse one cycle; HI=0, LO=42.
- MULTU X=Y=32'hFFFFFFFF → HI=32'hFFFFFFFE, LO=32'h00000001.
- DIVU X=100, Y=7 → LO=14, HI=2. DIVU X=5, Y=0 → Done after 1 busy cycle, HI=5, LO=32'hFFFFFFFF.
- Preload via HiWe/LoWe WData=32'hA5A5A5A5. Start MULTU 3×3, then assert Reset_n=0 at iteration 10 → IDLE, HI=LO=0, no Done. HiWe during MUL is ignored.
- With MDU_SIGNED_EN:
  - MULT −6×7 → HI=32'hFFFFFFFF, LO=32'hFFFFFFD6.
  - DIV −7/2 → LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
  - Stall 34 cycles.
